// File: rtl/hydra_pkg.sv
// Shared constants and types for the packet SRAM read path.
package hydra_pkg;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 16;
    localparam int SRAM_DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // One buffered SRAM word plus its end-of-burst marker.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } rd_word_t;

endpackage

// File: rtl/sram_reader_if.sv
// Request, SRAM read port and output stream of the SRAM reader.
// The master view is the reader itself; the slave view is its surroundings
// (request source, SRAM and egress logic).
interface sram_reader_if #(
    parameter int LEN_W = 7
);
    import hydra_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;

    logic              sram_rd_en;
    logic [ADDR_W-1:0] sram_rd_addr;
    logic [DATA_W-1:0] sram_dout;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        input  req_valid, req_addr, req_len, sram_dout, out_ready,
        output req_ready, sram_rd_en, sram_rd_addr, out_valid, out_data, out_last
    );

    modport slave (
        output req_valid, req_addr, req_len, sram_dout, out_ready,
        input  req_ready, sram_rd_en, sram_rd_addr, out_valid, out_data, out_last
    );

endinterface

// File: rtl/sram_rd_fifo.sv
// Small return buffer holding {last, data} words coming back from the SRAM.
// The reader's credit check keeps pushes from ever hitting a full buffer.
module sram_rd_fifo
    import hydra_pkg::*;
#(
    parameter int BUF_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  rd_word_t                   push_word,
    input  logic                       pop,
    output rd_word_t                   head_word,
    output logic [$clog2(BUF_DEPTH):0] occupancy,
    output logic                       empty
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    rd_word_t         mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;

    assign pop_ok    = pop && !empty;
    assign empty     = (occupancy == '0);
    assign head_word = mem[rd_ptr];

    // Storage write; contents need no reset because occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop_ok})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/sram_reader.sv
// Burst reader for the packet SRAM: issues one read per cycle while buffer
// credit allows, and streams the returned words out with a last-word flag.
module sram_reader
    import hydra_pkg::*;
#(
    parameter int LEN_W     = 7,
    parameter int BUF_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    sram_reader_if.master bus,
    output logic          busy
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    rd_state_t         state;
    rd_state_t         next_state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic              rd_pending;
    logic              last_pending;
    logic              rd_en;
    logic              accept;
    logic              pop;
    logic              fifo_empty;
    logic [CNT_W-1:0]  occupancy;
    logic [CNT_W:0]    credit_used;
    rd_word_t          push_word;
    rd_word_t          head_word;

    // Words already buffered plus the one still coming back from the SRAM.
    assign credit_used = {1'b0, occupancy} + (CNT_W + 1)'(rd_pending);
    assign accept      = (state == IDLE) && bus.req_valid && (bus.req_len != '0);
    assign pop         = !fifo_empty && bus.out_ready;
    assign push_word   = '{last: last_pending, data: bus.sram_dout};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; DRAIN ends once nothing is in flight and the buffer empties.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = READ;
                end
            end
            READ: begin
                if (rd_en && (remaining == LEN_W'(1))) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!rd_pending && (fifo_empty || (pop && (occupancy == CNT_W'(1))))) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State-derived outputs; a read goes out only while buffer credit remains.
    always_comb begin
        bus.req_ready    = (state == IDLE);
        busy             = (state != IDLE);
        rd_en            = (state == READ) && (remaining != '0) &&
                           (credit_used < (CNT_W + 1)'(BUF_DEPTH));
        bus.sram_rd_en   = rd_en;
        bus.sram_rd_addr = rd_en ? addr : '0;
    end

    // Burst address/length tracking and the one-cycle read-return marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr         <= '0;
            remaining    <= '0;
            rd_pending   <= 1'b0;
            last_pending <= 1'b0;
        end else begin
            if (accept) begin
                addr      <= bus.req_addr;
                remaining <= bus.req_len;
            end else if (rd_en) begin
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
            rd_pending   <= rd_en;
            last_pending <= rd_en && (remaining == LEN_W'(1));
        end
    end

    sram_rd_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pending),
        .push_word (push_word),
        .pop       (pop),
        .head_word (head_word),
        .occupancy (occupancy),
        .empty     (fifo_empty)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_empty ? '0 : head_word.data;
    assign bus.out_last  = fifo_empty ? 1'b0 : head_word.last;

endmodule
